// File: rtl/count_arbiter.sv
// count_arbiter: one shared up-counting timer, time-shared among NUM_REQ
// requesters with round-robin arbitration. The winner's delay is latched at
// grant, the counter runs from zero to that value, and the owner gets a
// one-cycle done pulse before the timer is released.
module count_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int COUNTER_SIZE = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*COUNTER_SIZE-1:0] delay,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic                            busy,
    output logic [COUNTER_SIZE-1:0]         cur_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    busy_q, busy_d;
    logic [COUNTER_SIZE-1:0] count_q, count_d;
    logic [COUNTER_SIZE-1:0] delay_q, delay_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic                    armed_q;

    logic                    win_found;
    logic [PTR_W-1:0]        win_idx;
    int                      scan_idx;

    // Round-robin search: first pending request at or above the pointer, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // Next-state logic for the IDLE -> RUN -> DONE timer ownership cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        count_d = count_q;
        delay_d = delay_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;

        unique case (state_q)
            S_IDLE: begin
                // armed_q keeps the first edge after reset release from granting.
                if (armed_q && win_found) begin
                    state_d          = S_RUN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    busy_d           = 1'b1;
                    count_d          = '0;
                    delay_d          = delay[win_idx*COUNTER_SIZE +: COUNTER_SIZE];
                    owner_d          = win_idx;
                    ptr_d            = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            S_RUN: begin
                // Match wins over abort; the counter holds at the match value.
                if (count_q == delay_q) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                end else if (!req[owner_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            delay_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            armed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            delay_q <= delay_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            armed_q <= 1'b1;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cur_count = count_q;

endmodule

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter: directed vector tables plus hand-written sequences for
// the long-delay boundary and asynchronous reset during a run.
module tb_count_arbiter;

    localparam int NR = 4;
    localparam int CS = 4;

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    req;
    logic [NR*CS-1:0] delay;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    done;
    logic             busy;
    logic [CS-1:0]    cur_count;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*CS-1:0] dly;
        logic [NR-1:0]    grant;
        logic [NR-1:0]    done;
        logic             busy;
        logic [CS-1:0]    count;
    } vec_t;

    vec_t vq[$];

    count_arbiter #(
        .NUM_REQ     (NR),
        .COUNTER_SIZE(CS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .delay    (delay),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .cur_count(cur_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [NR-1:0] r, input logic [NR*CS-1:0] d,
                       input logic [NR-1:0] g, input logic [NR-1:0] dn,
                       input logic b, input logic [CS-1:0] c);
        vec_t v;
        v.req = r; v.dly = d; v.grant = g; v.done = dn; v.busy = b; v.count = c;
        vq.push_back(v);
    endtask

    // Apply each row's inputs, clock once, then compare outputs just after the edge.
    task automatic run_vectors(input string name);
        for (int k = 0; k < vq.size(); k++) begin
            req   = vq[k].req;
            delay = vq[k].dly;
            @(posedge clk); #1;
            check($sformatf("%s[%0d].grant", name, k), 32'(grant), 32'(vq[k].grant));
            check($sformatf("%s[%0d].done", name, k), 32'(done), 32'(vq[k].done));
            check($sformatf("%s[%0d].busy", name, k), 32'(busy), 32'(vq[k].busy));
            check($sformatf("%s[%0d].count", name, k), 32'(cur_count), 32'(vq[k].count));
        end
        vq.delete();
    endtask

    // Reset with inputs idle; returns #1 after the first edge following release.
    task automatic do_reset();
        req     = '0;
        delay   = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        req     = '0;
        delay   = '0;

        #12;
        check("reset.grant", 32'(grant), 32'h0);
        check("reset.done", 32'(done), 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.count", 32'(cur_count), 32'h0);

        // Single request on requester 2, D=5: done seven cycles after request.
        do_reset();
        add(4'b0100, 16'h0500, 4'b0100, 4'b0000, 1'b1, 4'd0);
        for (int c = 1; c <= 5; c++)
            add(4'b0100, 16'h0500, 4'b0100, 4'b0000, 1'b1, CS'(c));
        add(4'b0100, 16'h0500, 4'b0100, 4'b0100, 1'b1, 4'd5);
        add(4'b0000, 16'h0500, 4'b0000, 4'b0000, 1'b0, 4'd0);
        add(4'b0000, 16'h0500, 4'b0000, 4'b0000, 1'b0, 4'd0);
        run_vectors("single");

        // All four holding req with D=0: grants 0,1,2,3,0 with idle gaps.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            add(4'b1111, 16'h0000, 4'(1 << r), 4'b0000, 1'b1, 4'd0);
            add(4'b1111, 16'h0000, 4'(1 << r), 4'(1 << r), 1'b1, 4'd0);
            add(4'b1111, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0);
        end
        add(4'b1111, 16'h0000, 4'b0001, 4'b0000, 1'b1, 4'd0);
        run_vectors("rr");

        // Abort: req[1] (D=10) drops at count 3; pending req[3] (D=1) follows.
        do_reset();
        for (int c = 0; c <= 3; c++)
            add(4'b1010, 16'h10A0, 4'b0010, 4'b0000, 1'b1, CS'(c));
        add(4'b1000, 16'h10A0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        add(4'b1000, 16'h10A0, 4'b1000, 4'b0000, 1'b1, 4'd0);
        add(4'b1000, 16'h10A0, 4'b1000, 4'b0000, 1'b1, 4'd1);
        add(4'b1000, 16'h10A0, 4'b1000, 4'b1000, 1'b1, 4'd1);
        add(4'b0000, 16'h10A0, 4'b0000, 4'b0000, 1'b0, 4'd0);
        run_vectors("abort");

        // Boundary: D=15 on a 4-bit counter, delay input changed mid-run.
        do_reset();
        begin
            int n;
            req   = 4'b0001;
            delay = 16'h000F;
            @(posedge clk); #1;
            check("bound.grant", 32'(grant), 32'h1);
            check("bound.count0", 32'(cur_count), 32'h0);
            n = 0;
            while (n < 40 && done == '0) begin
                n++;
                if (n == 3) delay = 16'h0002;
                @(posedge clk); #1;
            end
            check("bound.cycles_to_done", 32'(n), 32'd16);
            check("bound.count_at_done", 32'(cur_count), 32'hF);
            check("bound.done", 32'(done), 32'h1);
            check("bound.grant_at_done", 32'(grant), 32'h1);
            req = '0;
            @(posedge clk); #1;
            check("bound.released", 32'(grant), 32'h0);
        end

        // Asynchronous reset in the middle of a run.
        do_reset();
        req   = 4'b0010;
        delay = 16'h00A0;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid.pre_count", 32'(cur_count), 32'h2);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("rstmid.grant", 32'(grant), 32'h0);
        check("rstmid.done", 32'(done), 32'h0);
        check("rstmid.busy", 32'(busy), 32'h0);
        check("rstmid.count", 32'(cur_count), 32'h0);
        req   = 4'b1001;
        delay = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rstmid.first_edge_grant", 32'(grant), 32'h0);
        @(posedge clk); #1;
        check("rstmid.ptr0_wins", 32'(grant), 32'h1);

        reset_n = 1'b0;
        req     = 4'b1000;
        #3;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rstmid.req3_wins", 32'(grant), 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
